// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int SYNC_DEPTH = 2;
    localparam int MIN_CNT_W  = 1;

    // Rounded integer divide so the tick period lands on the nearest whole clock count.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : MIN_CNT_W;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running prescaler producing a one-clock tick every DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 22
) (
    input  logic clk,
    input  logic rst,
    output logic tick_en
);

    localparam int CNT_W = cnt_w(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_en = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote and valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o port.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 40_500_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rxd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err_o,
`endif
    output logic              overrun_o
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = cnt_w(DATA_W);
    localparam logic [OS_W-1:0]  SMP_A    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_B    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_C    = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic              rxd_p0, rxd_p1, rxd_s;
    logic              tick_en, mid_tick, vote;
    logic              smp_a, smp_b;
    logic [OS_W-1:0]   s_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    rx_state_e         state, state_nx;
    logic              done_p0, done_nx, ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic              par_bad, perr_nx;
`endif

    // Stage 0/1: two-flop synchroniser, idles high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd_i;
            rxd_p1 <= rxd_p0;
        end
    end
    assign rxd_s = rxd_p1;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk_i),
        .rst     (rst_i),
        .tick_en (tick_en)
    );

    // Third vote sample is taken live, so the decision lands on the SMP_C tick.
    assign mid_tick = tick_en && (s_cnt == SMP_C);
    assign vote     = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_nx  = 1'b0;
`endif
        case (state)
            IDLE:  if (tick_en && !rxd_s) state_nx = START;
            START: if (mid_tick) state_nx = vote ? IDLE : DATA;
            DATA: begin
                if (mid_tick && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_tick) begin
                    state_nx = STOP;
                    perr_nx  = (vote != (^shreg));
                end
            end
`endif
            STOP: begin
                if (mid_tick) begin
                    if (vote) begin
                        state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
                        done_nx  = !par_bad;
`else
                        done_nx  = 1'b1;
`endif
                    end else begin
                        state_nx = BREAK;
                        ferr_nx  = 1'b1;
                    end
                end
            end
            BREAK:   if (tick_en && rxd_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            done_p0     <= 1'b0;
            frame_err_o <= 1'b0;
            s_cnt       <= '0;
            bit_cnt     <= '0;
        end else begin
            state       <= state_nx;
            done_p0     <= done_nx;
            frame_err_o <= ferr_nx;
            if (state == IDLE || state == BREAK) begin
                s_cnt <= '0;
            end else if (tick_en) begin
                s_cnt <= s_cnt + OS_W'(1);
            end
            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA && mid_tick) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= perr_nx;
            if (state == IDLE)  par_bad <= 1'b0;
            else if (perr_nx)   par_bad <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (tick_en && s_cnt == SMP_A) smp_a <= rxd_s;
        if (tick_en && s_cnt == SMP_B) smp_b <= rxd_s;
        if (state == DATA && mid_tick) shreg <= {vote, shreg[DATA_W-1:1]};
    end

    // Stage 2: output register; a completion with a full, unaccepted output is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done_p0) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
